// File: rtl/cpu_control_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_isa_pkg
// Brief    : CR16-subset opcodes, ALU codes, condition codes, flag indices
//            and sequencer state encoding.
// Revision : 1.0
// ============================================================================
package cpu_isa_pkg;

    localparam logic [3:0] c_OP_RR      = 4'h0;
    localparam logic [3:0] c_OP_MEM     = 4'h4;
    localparam logic [3:0] c_OP_BCC     = 4'hC;

    localparam logic [3:0] c_ALU_AND    = 4'h1;
    localparam logic [3:0] c_ALU_OR     = 4'h2;
    localparam logic [3:0] c_ALU_XOR    = 4'h3;
    localparam logic [3:0] c_ALU_ADD    = 4'h5;
    localparam logic [3:0] c_ALU_SUB    = 4'h9;
    localparam logic [3:0] c_ALU_CMP    = 4'hB;
    localparam logic [3:0] c_ALU_MOV    = 4'hD;
    localparam logic [3:0] c_ALU_LUI    = 4'hF;
    localparam logic [7:0] c_ALU_OP_MOV = {c_OP_RR, c_ALU_MOV};

    localparam logic [3:0] c_EXT_WAIT   = 4'h0;
    localparam logic [3:0] c_EXT_LOAD   = 4'h0;
    localparam logic [3:0] c_EXT_STORE  = 4'h4;
    localparam logic [3:0] c_EXT_JUMP   = 4'hC;

    localparam logic [3:0] c_CC_EQ = 4'h0;
    localparam logic [3:0] c_CC_NE = 4'h1;
    localparam logic [3:0] c_CC_CS = 4'h2;
    localparam logic [3:0] c_CC_CC = 4'h3;
    localparam logic [3:0] c_CC_HI = 4'h4;
    localparam logic [3:0] c_CC_LS = 4'h5;
    localparam logic [3:0] c_CC_GT = 4'h6;
    localparam logic [3:0] c_CC_LE = 4'h7;
    localparam logic [3:0] c_CC_FS = 4'h8;
    localparam logic [3:0] c_CC_FC = 4'h9;
    localparam logic [3:0] c_CC_LO = 4'hA;
    localparam logic [3:0] c_CC_HS = 4'hB;
    localparam logic [3:0] c_CC_LT = 4'hC;
    localparam logic [3:0] c_CC_GE = 4'hD;
    localparam logic [3:0] c_CC_UC = 4'hE;
    localparam logic [3:0] c_CC_NV = 4'hF;

    localparam int c_FLAG_N = 0;
    localparam int c_FLAG_Z = 1;
    localparam int c_FLAG_F = 2;
    localparam int c_FLAG_L = 3;
    localparam int c_FLAG_C = 4;

    // Nine behaviours share a 3-bit debug port, so BRANCH also resolves JUMP
    // (told apart by the opcode held in the IR).
    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_LD_ADDR = 3'd3,
        S_LD_WB   = 3'd4,
        S_STORE   = 3'd5,
        S_BRANCH  = 3'd6,
        S_HALT    = 3'd7
    } state_t;

    function automatic logic is_rr_alu(input logic [3:0] code);
        return code inside {c_ALU_ADD, c_ALU_SUB, c_ALU_CMP, c_ALU_AND,
                            c_ALU_OR, c_ALU_XOR, c_ALU_MOV};
    endfunction

    function automatic logic is_imm_alu(input logic [3:0] op);
        return is_rr_alu(op) || (op == c_ALU_LUI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_control_fsm_if
// Brief    : Sequencer <-> datapath control/bus bundle.
// Revision : 1.0
// ============================================================================
interface cpu_control_fsm_if #(
    parameter int PC_W  = 16,
    parameter int NREGS = 16
);
    logic [15:0]       instr;
    logic [4:0]        flag_reg;
    logic [15:0]       bus_in;
    logic [PC_W-1:0]   pc;
    logic              mem_addr_sel;
    logic              mem_we;
    logic [NREGS-1:0]  reg_en;
    logic [3:0]        mux_a;
    logic [3:0]        mux_b;
    logic [7:0]        alu_op;
    logic [15:0]       imm;
    logic              imm_sel;
    logic              cin;
    logic              flag_en;
    logic              alu_buf_en;
    logic              mem_buf_en;
    logic [2:0]        state_o;

    modport master (
        input  instr, flag_reg, bus_in,
        output pc, mem_addr_sel, mem_we, reg_en, mux_a, mux_b, alu_op, imm,
               imm_sel, cin, flag_en, alu_buf_en, mem_buf_en, state_o
    );

    modport slave (
        output instr, flag_reg, bus_in,
        input  pc, mem_addr_sel, mem_we, reg_en, mux_a, mux_b, alu_op, imm,
               imm_sel, cin, flag_en, alu_buf_en, mem_buf_en, state_o
    );
endinterface
`default_nettype wire

// File: rtl/cpu_control_fsm_cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : cond_eval
// Brief    : Evaluates a 4-bit condition code against the {C,L,F,Z,N} flags.
// Revision : 1.0
// ============================================================================
module cond_eval
    import cpu_isa_pkg::*;
(
    input  wire logic [4:0] i_flags,
    input  wire logic [3:0] i_cond,
    output logic            o_taken
);
    logic w_c, w_l, w_f, w_z, w_n;

    assign w_c = i_flags[c_FLAG_C];
    assign w_l = i_flags[c_FLAG_L];
    assign w_f = i_flags[c_FLAG_F];
    assign w_z = i_flags[c_FLAG_Z];
    assign w_n = i_flags[c_FLAG_N];

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            c_CC_EQ: o_taken = w_z;
            c_CC_NE: o_taken = !w_z;
            c_CC_CS: o_taken = w_c;
            c_CC_CC: o_taken = !w_c;
            c_CC_HI: o_taken = w_l;
            c_CC_LS: o_taken = !w_l;
            c_CC_GT: o_taken = w_n;
            c_CC_LE: o_taken = !w_n;
            c_CC_FS: o_taken = w_f;
            c_CC_FC: o_taken = !w_f;
            c_CC_LO: o_taken = !w_l && !w_z;
            c_CC_HS: o_taken = w_l || w_z;
            c_CC_LT: o_taken = !w_n && !w_z;
            c_CC_GE: o_taken = w_n || w_z;
            c_CC_UC: o_taken = 1'b1;
            c_CC_NV: o_taken = 1'b0;
            default: o_taken = 1'b0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cpu_control_fsm
// Brief    : Multi-cycle CR16-subset sequencer owning PC/IR; Moore control.
// Revision : 1.0
// ============================================================================
module cpu_control_fsm
    import cpu_isa_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int NREGS = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    cpu_control_fsm_if.master bus
);
    state_t            r_state, w_state_nxt;
    logic [PC_W-1:0]   r_pc, w_pc_nxt, w_pc_inc, w_pc_rel, w_pc_jmp;
    logic [15:0]       r_ir, w_ir_nxt, w_imm_ext;
    logic [3:0]        w_op, w_rd, w_ext, w_rs, w_code, w_dop, w_dext;
    logic [7:0]        w_imm8;
    logic [NREGS-1:0]  w_rd_onehot;
    logic              w_taken;

    assign w_op        = r_ir[15:12];
    assign w_rd        = r_ir[11:8];
    assign w_ext       = r_ir[7:4];
    assign w_rs        = r_ir[3:0];
    assign w_imm8      = r_ir[7:0];
    assign w_dop       = bus.instr[15:12];
    assign w_dext      = bus.instr[7:4];
    assign w_code      = (w_op == c_OP_RR) ? w_ext : w_op;
    assign w_rd_onehot = NREGS'(1) << w_rd;
    assign w_pc_inc    = r_pc + PC_W'(1);
    assign w_pc_rel    = r_pc + PC_W'(signed'(w_imm8));
    assign w_pc_jmp    = PC_W'(bus.bus_in);

    always_comb begin
        case (w_op)
            c_ALU_AND, c_ALU_OR, c_ALU_XOR: w_imm_ext = {8'h00, w_imm8};
            c_ALU_LUI:                      w_imm_ext = {w_imm8, 8'h00};
            default:                        w_imm_ext = {{8{w_imm8[7]}}, w_imm8};
        endcase
    end

    cond_eval u_cond_eval (
        .i_flags (bus.flag_reg),
        .i_cond  (w_rd),
        .o_taken (w_taken)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
        end
    end

    assign bus.pc      = r_pc;
    assign bus.state_o = r_state;
    assign bus.cin     = 1'b0;

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ir_nxt         = r_ir;
        bus.mem_addr_sel = 1'b0;
        bus.mem_we       = 1'b0;
        bus.reg_en       = '0;
        bus.mux_a        = '0;
        bus.mux_b        = '0;
        bus.alu_op       = '0;
        bus.imm          = '0;
        bus.imm_sel      = 1'b0;
        bus.flag_en      = 1'b0;
        bus.alu_buf_en   = 1'b0;
        bus.mem_buf_en   = 1'b0;
        unique case (r_state)
            S_FETCH: w_state_nxt = S_DECODE;
            // Only place instr steers anything; no strobe is raised here.
            S_DECODE: begin
                w_ir_nxt = bus.instr;
                if (w_dop == c_OP_RR && w_dext == c_EXT_WAIT)
                    w_state_nxt = S_HALT;
                else if ((w_dop == c_OP_RR && is_rr_alu(w_dext)) || is_imm_alu(w_dop))
                    w_state_nxt = S_EXEC;
                else if (w_dop == c_OP_MEM && w_dext == c_EXT_LOAD)
                    w_state_nxt = S_LD_ADDR;
                else if (w_dop == c_OP_MEM && w_dext == c_EXT_STORE)
                    w_state_nxt = S_STORE;
                else if ((w_dop == c_OP_MEM && w_dext == c_EXT_JUMP) || w_dop == c_OP_BCC)
                    w_state_nxt = S_BRANCH;
                else begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = w_pc_inc;
                end
            end
            S_EXEC: begin
                bus.mux_a      = w_rd;
                bus.alu_buf_en = 1'b1;
                if (w_op == c_OP_RR) begin
                    bus.mux_b  = w_rs;
                    bus.alu_op = {w_op, w_ext};
                end else begin
                    bus.imm_sel = 1'b1;
                    bus.imm     = w_imm_ext;
                    bus.alu_op  = {w_op, 4'h0};
                end
                if (w_code != c_ALU_CMP)
                    bus.reg_en = w_rd_onehot;
                bus.flag_en = (w_code == c_ALU_ADD) || (w_code == c_ALU_SUB) ||
                              (w_code == c_ALU_CMP);
                w_pc_nxt    = w_pc_inc;
                w_state_nxt = S_FETCH;
            end
            S_LD_ADDR: begin
                bus.mux_a        = w_rs;
                bus.mux_b        = w_rs;
                bus.alu_op       = c_ALU_OP_MOV;
                bus.alu_buf_en   = 1'b1;
                bus.mem_addr_sel = 1'b1;
                w_state_nxt      = S_LD_WB;
            end
            S_LD_WB: begin
                bus.mem_buf_en = 1'b1;
                bus.reg_en     = w_rd_onehot;
                w_pc_nxt       = w_pc_inc;
                w_state_nxt    = S_FETCH;
            end
            S_STORE: begin
                bus.mux_a        = w_rd;
                bus.mux_b        = w_rs;
                bus.alu_op       = c_ALU_OP_MOV;
                bus.alu_buf_en   = 1'b1;
                bus.mem_addr_sel = 1'b1;
                bus.mem_we       = 1'b1;
                w_pc_nxt         = w_pc_inc;
                w_state_nxt      = S_FETCH;
            end
            S_BRANCH: begin
                if (w_op == c_OP_BCC) begin
                    w_pc_nxt = w_taken ? w_pc_rel : w_pc_inc;
                end else begin
                    bus.mux_a      = w_rs;
                    bus.mux_b      = w_rs;
                    bus.alu_op     = c_ALU_OP_MOV;
                    bus.alu_buf_en = 1'b1;
                    w_pc_nxt       = w_taken ? w_pc_jmp : w_pc_inc;
                end
                w_state_nxt = S_FETCH;
            end
            S_HALT: w_state_nxt = S_HALT;
            default: w_state_nxt = S_FETCH;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_control_fsm
// Brief    : Scoreboard bench for the instruction sequencer.
// Revision : 1.0
// ============================================================================
module tb_cpu_control_fsm;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cpu_control_fsm_if #(.PC_W(16), .NREGS(16)) bus ();

    cpu_control_fsm #(.PC_W(16), .NREGS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [15:0] pc;
        logic [15:0] reg_en;
        logic        mem_addr_sel, mem_we, flag_en, alu_buf_en, mem_buf_en, imm_sel;
        bit          care_a, care_b, care_op, care_imm;
        logic [3:0]  mux_a, mux_b;
        logic [7:0]  alu_op;
        logic [15:0] imm;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] pc_m;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t base(input string tag, input logic [2:0] st);
        exp_t e;
        e.tag = tag; e.st = st; e.pc = pc_m; e.reg_en = '0;
        e.mem_addr_sel = 0; e.mem_we = 0; e.flag_en = 0; e.alu_buf_en = 0;
        e.mem_buf_en = 0; e.imm_sel = 0;
        e.care_a = 0; e.care_b = 0; e.care_op = 0; e.care_imm = 0;
        e.mux_a = '0; e.mux_b = '0; e.alu_op = '0; e.imm = '0;
        return e;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset) begin
            chk_eq("rst.state",   32'(bus.state_o), 32'd0);
            chk_eq("rst.pc",      32'(bus.pc), 32'd0);
            chk_eq("rst.reg_en",  32'(bus.reg_en), 32'd0);
            chk_eq("rst.strobes", 32'({bus.mem_we, bus.flag_en, bus.alu_buf_en,
                                       bus.mem_buf_en, bus.mem_addr_sel}), 32'd0);
        end else begin
            chk_eq("inv.one_buf", 32'(bus.alu_buf_en & bus.mem_buf_en), 32'd0);
            chk_eq("inv.onehot0", 32'($onehot0(bus.reg_en)), 32'd1);
            chk_eq("inv.cin",     32'(bus.cin), 32'd0);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk_eq({e.tag, ".state"},   32'(bus.state_o), 32'(e.st));
                chk_eq({e.tag, ".pc"},      32'(bus.pc), 32'(e.pc));
                chk_eq({e.tag, ".reg_en"},  32'(bus.reg_en), 32'(e.reg_en));
                chk_eq({e.tag, ".strobes"},
                       32'({bus.mem_addr_sel, bus.mem_we, bus.flag_en, bus.alu_buf_en,
                            bus.mem_buf_en, bus.imm_sel}),
                       32'({e.mem_addr_sel, e.mem_we, e.flag_en, e.alu_buf_en,
                            e.mem_buf_en, e.imm_sel}));
                if (e.care_a)   chk_eq({e.tag, ".mux_a"},  32'(bus.mux_a), 32'(e.mux_a));
                if (e.care_b)   chk_eq({e.tag, ".mux_b"},  32'(bus.mux_b), 32'(e.mux_b));
                if (e.care_op)  chk_eq({e.tag, ".alu_op"}, 32'(bus.alu_op), 32'(e.alu_op));
                if (e.care_imm) chk_eq({e.tag, ".imm"},    32'(bus.imm), 32'(e.imm));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_fd(input string tag, input logic [15:0] ins);
        bus.instr = ins;
        sb.push_back(base({tag, ".F"}, 3'd0));
        sb.push_back(base({tag, ".D"}, 3'd1));
    endtask

    task automatic run_alu(input string tag, input logic [15:0] ins, input logic [15:0] ren,
                           input logic fen, input bit rr, input logic [15:0] imm,
                           input logic [7:0] op);
        exp_t e;
        push_fd(tag, ins);
        e = base({tag, ".X"}, 3'd2);
        e.reg_en = ren; e.flag_en = fen; e.alu_buf_en = 1'b1;
        e.care_a = 1; e.mux_a = ins[11:8];
        if (rr) begin
            e.care_b = 1; e.mux_b = ins[3:0]; e.care_op = 1; e.alu_op = op;
        end else begin
            e.imm_sel = 1'b1; e.care_imm = 1; e.imm = imm;
        end
        sb.push_back(e);
        cyc(3);
        pc_m = pc_m + 16'd1;
    endtask

    task automatic run_load(input string tag, input logic [15:0] ins, input logic [15:0] ren,
                            input bit abort);
        exp_t e;
        push_fd(tag, ins);
        e = base({tag, ".LA"}, 3'd3);
        e.mem_addr_sel = 1'b1; e.alu_buf_en = 1'b1;
        e.care_a = 1; e.mux_a = ins[3:0]; e.care_op = 1; e.alu_op = 8'h0D;
        sb.push_back(e);
        if (!abort) begin
            e = base({tag, ".WB"}, 3'd4);
            e.mem_buf_en = 1'b1; e.reg_en = ren;
            sb.push_back(e);
        end
        cyc(2);
        bus.instr = 16'hBEEF;
        cyc(1);
        if (abort) begin
            reset = 1'b0;
            cyc(3);
            reset = 1'b1;
            pc_m  = 16'h0000;
        end else begin
            cyc(1);
            pc_m = pc_m + 16'd1;
        end
    endtask

    task automatic run_store(input string tag, input logic [15:0] ins);
        exp_t e;
        push_fd(tag, ins);
        e = base({tag, ".S"}, 3'd5);
        e.mem_addr_sel = 1'b1; e.mem_we = 1'b1; e.alu_buf_en = 1'b1;
        e.care_a = 1; e.mux_a = ins[11:8]; e.care_op = 1; e.alu_op = 8'h0D;
        sb.push_back(e);
        cyc(3);
        pc_m = pc_m + 16'd1;
    endtask

    task automatic run_ctl(input string tag, input logic [15:0] ins, input logic [4:0] flags,
                           input logic [15:0] busv, input logic [15:0] pc_next);
        exp_t e;
        bus.flag_reg = flags;
        bus.bus_in   = busv;
        push_fd(tag, ins);
        e = base({tag, ".B"}, 3'd6);
        if (ins[15:12] == 4'h4) begin
            e.alu_buf_en = 1'b1; e.care_a = 1; e.mux_a = ins[3:0];
            e.care_op = 1; e.alu_op = 8'h0D;
        end
        sb.push_back(e);
        cyc(3);
        pc_m = pc_next;
    endtask

    task automatic run_nop(input string tag, input logic [15:0] ins);
        push_fd(tag, ins);
        cyc(2);
        pc_m = pc_m + 16'd1;
    endtask

    initial begin
        bus.instr    = 16'h0000;
        bus.flag_reg = 5'b0;
        bus.bus_in   = 16'h0000;
        pc_m         = 16'h0000;
        #1 reset = 1'b0;
        cyc(2);
        reset = 1'b1;

        run_alu("add",  16'h0351, 16'h0008, 1'b1, 1, 16'h0000, 8'h05);
        run_alu("cmpi", 16'hB2FF, 16'h0000, 1'b1, 0, 16'hFFFF, 8'h00);
        run_alu("andi", 16'h1480, 16'h0010, 1'b0, 0, 16'h0080, 8'h00);
        run_alu("lui",  16'hF612, 16'h0040, 1'b0, 0, 16'h1200, 8'h00);
        run_alu("sub",  16'h0792, 16'h0080, 1'b1, 1, 16'h0000, 8'h09);
        run_alu("movi", 16'hDFFE, 16'h8000, 1'b0, 0, 16'hFFFE, 8'h00);
        run_alu("xor",  16'h0131, 16'h0002, 1'b0, 1, 16'h0000, 8'h03);
        run_load("load", 16'h4501, 16'h0020, 0);
        run_store("store", 16'h4942);
        run_nop("nop", 16'h6000);
        run_ctl("jmp_uc",  16'h4EC3, 5'b00000, 16'h0002, 16'h0002);
        run_ctl("beq_t",   16'hC0FC, 5'b00010, 16'h0000, 16'hFFFE);
        run_ctl("jmp_uc2", 16'h4EC3, 5'b00000, 16'h0002, 16'h0002);
        run_ctl("beq_nt",  16'hC0FC, 5'b00000, 16'h0000, 16'h0003);
        run_ctl("jmp_nv",  16'h4FC3, 5'b11111, 16'h1234, 16'h0004);
        run_ctl("jmp_max", 16'h4EC3, 5'b00000, 16'hFFFF, 16'hFFFF);
        run_nop("nop_wrap", 16'h6000);
        run_ctl("blo_t",   16'hCA03, 5'b00000, 16'h0000, 16'h0003);
        run_ctl("bgt_nt",  16'hC605, 5'b00000, 16'h0000, 16'h0004);

        push_fd("wait", 16'h0000);
        for (int i = 0; i < 20; i++) sb.push_back(base("halt", 3'd7));
        cyc(22);
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        pc_m = 16'h0000;

        run_load("ld_abort", 16'h4501, 16'h0020, 1);
        run_alu("add2", 16'h0351, 16'h0008, 1'b1, 1, 16'h0000, 8'h05);
        sb.push_back(base("final.F", 3'd0));
        cyc(1);
        chk_eq("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
- Multi-cycle instruction sequencer for the 16-bit CPU.
- Owns the PC and the IR, and decodes a CR16-subset ISA.
- Drives every datapath control line: register-bank write enables, A/B read-mux selects, ALU op/immediate/flag enable, the ALU and RAM tri-state bus enables, and RAM address select/write enable.
- Sits at the CPU top level beside the reg bank, ALU register and block RAM.

Parameters:
- PC_W, 16, program counter / RAM address width
- NREGS, 16, register count; reg_en width, 4-bit register fields

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- instr  in  16  RAM read data; valid the cycle after an address is presented
- flag_reg  in  5  ALU flag register {C,L,F,Z,N}
- bus_in  in  16  shared result bus; jump targets and load addresses
- pc  out  PC_W  program counter
- mem_addr_sel  out  1  RAM address source: 0 = pc, 1 = bus_in
- mem_we  out  1  RAM write enable; write data = reg bank A port, wired externally
- reg_en  out  NREGS  one-hot register write enable
- mux_a  out  4  reg bank A-side select
- mux_b  out  4  reg bank B-side select
- alu_op  out  8  {opcode, opext}; codes from the package
- imm  out  16  extended immediate
- imm_sel  out  1  ALU B operand: 1 = imm, 0 = mux_b
- cin  out  1  ALU carry-in; constant 0 in this revision
- flag_en  out  1  flag register load
- alu_buf_en  out  1  ALU tri-state onto bus
- mem_buf_en  out  1  RAM tri-state onto bus
- state_o  out  3  current state, debug

Behaviour:
- Reset (reset = 0, async): pc = 0, ir = 0, state = FETCH, all enables/strobes = 0, selects = 0.
  - Reset mid-instruction aborts immediately; no reg_en or mem_we pulse after the reset edge.
- Decoding uses ir fields: op = ir[15:12], rd = ir[11:8], ext = ir[7:4], rs = ir[3:0], imm8 = ir[7:0].
- FETCH: mem_addr_sel = 0 → DECODE.
- DECODE: ir <= instr; next state by opcode:
  - op 0000 or immediate ops → EXEC
  - 0100/0000 → LD_ADDR
  - 0100/0100 → STORE
  - 0100/1100 → JUMP
  - 1100 → BRANCH
  - 0000/0000 (WAIT) → HALT
  - anything else: NOP → FETCH with pc+1
- EXEC (register-register, ext = ADD 0101, SUB 1001, CMP 1011, AND 0001, OR 0010, XOR 0011, MOV 1101):
  - mux_a = rd, mux_b = rs, imm_sel = 0, alu_buf_en = 1
  - reg_en[rd] = 1 except CMP
  - flag_en = 1 for ADD/SUB/CMP
  - pc <= pc+1 → FETCH
- EXEC (immediate, op = ADDI 0101, SUBI 1001, CMPI 1011, ANDI 0001, ORI 0010, XORI 0011, MOVI 1101, LUI 1111):
  - imm_sel = 1
  - imm = sign-extended imm8 for ADDI/SUBI/CMPI/MOVI; zero-extended for ANDI/ORI/XORI; {imm8, 8'h00} for LUI
  - Enables as for the register form.
- LD_ADDR: mux_a = rs, alu_op = MOV, alu_buf_en = 1, mem_addr_sel = 1 → LD_WB.
- LD_WB: mem_buf_en = 1, reg_en[rd] = 1, pc+1 → FETCH.
- STORE: mux_a = rd (data), address = rs routed via ALU MOV onto the bus, mem_addr_sel = 1, mem_we = 1 for exactly one cycle, pc+1 → FETCH.
- BRANCH: if cond(rd) holds, pc <= pc + sext(imm8), else pc+1 → FETCH.
- JUMP: rs is passed via MOV onto the bus; if cond(rd) holds, pc <= bus_in, else pc+1 → FETCH.
- Condition codes:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 HI L; 5 LS !L; 6 GT N; 7 LE !N
  - 8 FS F; 9 FC !F; A LO !L&!Z; B HS L|Z; C LT !N&!Z; D GE N|Z; E UC 1; F never 0
- Flags are sampled combinationally in BRANCH/JUMP; the preceding instruction's flag_en has already registered.
- HALT: all strobes 0; exits only on reset.
- Latency: ALU/branch/jump/store 3 cycles, load 4 cycles.
- Arithmetic: pc wraps modulo 2^PC_W, e.g. 0xFFFF+1 = 0x0000, and 0x0002 + sext(0xFC) = 0xFFFE.
- Invariants:
  - At most one of alu_buf_en/mem_buf_en is high per cycle.
  - reg_en is one-hot or zero.
- Outputs are registered-state decoded (Moore); no combinational path from instr to strobes except in DECODE (none asserted).

Decomposition:
- Package cpu_isa_pkg: opcode/ext localparams, condition-code constants, state enum encoding, flag bit indices.
- Sub-module cond_eval (flag_reg, cond → taken), shared with any future predicated ops.

Test Plan:
- Reset low mid-LD_WB with reset released later → reg_en never pulses; pc = 0, state = FETCH, all outputs 0.
- Instruction 0x0351 (ADD r3,r1) → DECODE, then EXEC with mux_a = 3, mux_b = 1, reg_en = 0x0008, flag_en = 1, alu_buf_en = 1; pc 0 → 1 after 3 cycles.
- 0xB2FF (CMPI r2,-1) → imm = 0xFFFF, imm_sel = 1, flag_en = 1, reg_en = 0.
- 0x4501 LOAD r5,[r1] with RAM returning 0xBEEF → LD_ADDR asserts mem_addr_sel = 1; LD_WB asserts mem_buf_en with reg_en = 0x0020; only one buffer enabled per cycle; 4 cycles total.
- 0xC0FC BEQ -4 at pc = 2: Z = 1 → pc = 0xFFFE; Z = 0 → pc = 3.
- 0x0000 WAIT → HALT; 20 cycles with no strobes and pc frozen; then reset → FETCH.
